// File: rtl/aw_xbar_router_if.sv
// AW-channel bundle between the crossbar and its attached masters/slaves.
// Modport master is the crossbar's view; modport slave is the surrounding bus environment.
interface aw_xbar_router_if #(
  parameter int NUM_M  = 3,
  parameter int NUM_S  = 8,
  parameter int ID_W   = 4,
  parameter int ADDR_W = 32,
  parameter int LEN_W  = 4,
  parameter int SIZE_W = 3
);
  localparam int MW = $clog2(NUM_M);
  localparam int IW = ID_W + MW;

  logic [NUM_M*ID_W-1:0]   AWID_M;
  logic [NUM_M*ADDR_W-1:0] AWADDR_M;
  logic [NUM_M*LEN_W-1:0]  AWLEN_M;
  logic [NUM_M*SIZE_W-1:0] AWSIZE_M;
  logic [NUM_M*2-1:0]      AWBURST_M;
  logic [NUM_M-1:0]        AWVALID_M;
  logic [NUM_M-1:0]        AWREADY_M;

  logic [NUM_S*IW-1:0]     AWID_S;
  logic [NUM_S*ADDR_W-1:0] AWADDR_S;
  logic [NUM_S*LEN_W-1:0]  AWLEN_S;
  logic [NUM_S*SIZE_W-1:0] AWSIZE_S;
  logic [NUM_S*2-1:0]      AWBURST_S;
  logic [NUM_S-1:0]        AWVALID_S;
  logic [NUM_S-1:0]        AWREADY_S;

  logic [NUM_S-1:0]        WROUTE_VALID;
  logic [NUM_S*MW-1:0]     WROUTE_MST;
  logic [NUM_S-1:0]        WROUTE_READY;

  modport master (
    input  AWID_M, AWADDR_M, AWLEN_M, AWSIZE_M, AWBURST_M, AWVALID_M,
    output AWREADY_M,
    output AWID_S, AWADDR_S, AWLEN_S, AWSIZE_S, AWBURST_S, AWVALID_S,
    input  AWREADY_S,
    output WROUTE_VALID, WROUTE_MST,
    input  WROUTE_READY
  );

  modport slave (
    output AWID_M, AWADDR_M, AWLEN_M, AWSIZE_M, AWBURST_M, AWVALID_M,
    input  AWREADY_M,
    input  AWID_S, AWADDR_S, AWLEN_S, AWSIZE_S, AWBURST_S, AWVALID_S,
    output AWREADY_S,
    input  WROUTE_VALID, WROUTE_MST,
    output WROUTE_READY
  );
endinterface

// File: rtl/aw_xbar_router.sv
// AXI write-address crossbar: per-slave round-robin arbitration with grant held to the
// AW handshake, AWID extended with the master index, and an in-order W-route push per AW.
module aw_xbar_router #(
  parameter int NUM_M   = 3,
  parameter int NUM_S   = 8,
  parameter int ID_W    = 4,
  parameter int ADDR_W  = 32,
  parameter int LEN_W   = 4,
  parameter int SIZE_W  = 3,
  parameter int SEL_LSB = 16
) (
  input logic            ACLK,
  input logic            ARESET,
  aw_xbar_router_if.master bus
);
  localparam int MW = $clog2(NUM_M);
  localparam int SW = $clog2(NUM_S);
  localparam int IW = ID_W + MW;

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_e;

  state_e          state_q [NUM_S];
  state_e          state_d [NUM_S];
  logic [MW-1:0]   gnt_q   [NUM_S];
  logic [MW-1:0]   gnt_d   [NUM_S];
  logic [MW-1:0]   ptr_q   [NUM_S];
  logic [MW-1:0]   ptr_d   [NUM_S];

  logic [SW-1:0]   dec     [NUM_M];
  logic [NUM_M-1:0] req    [NUM_S];
  logic [NUM_S-1:0] pick_vld;
  logic [MW-1:0]   pick_m  [NUM_S];
  logic [NUM_S-1:0] hs;

  // Out-of-range slave indices fall through to the last slave.
  always_comb begin
    for (int m = 0; m < NUM_M; m++) begin
      dec[m] = bus.AWADDR_M[m*ADDR_W+SEL_LSB +: SW];
      if (32'(dec[m]) >= 32'(NUM_S)) dec[m] = SW'(NUM_S-1);
    end
  end

  always_comb begin
    for (int s = 0; s < NUM_S; s++) begin
      for (int m = 0; m < NUM_M; m++) begin
        req[s][m] = bus.AWVALID_M[m] && (dec[m] == SW'(s));
      end
    end
  end

  // Round-robin scan starting at ptr_q, wrapping modulo NUM_M.
  always_comb begin
    int cand;
    cand     = 0;
    pick_vld = '0;
    for (int s = 0; s < NUM_S; s++) begin
      pick_m[s] = '0;
      for (int k = 0; k < NUM_M; k++) begin
        cand = int'(ptr_q[s]) + k;
        if (cand >= NUM_M) cand = cand - NUM_M;
        if (!pick_vld[s] && req[s][cand]) begin
          pick_vld[s] = 1'b1;
          pick_m[s]   = MW'(cand);
        end
      end
    end
  end

  always_comb begin
    int g;
    g                = 0;
    hs               = '0;
    bus.AWREADY_M    = '0;
    bus.AWID_S       = '0;
    bus.AWADDR_S     = '0;
    bus.AWLEN_S      = '0;
    bus.AWSIZE_S     = '0;
    bus.AWBURST_S    = '0;
    bus.AWVALID_S    = '0;
    bus.WROUTE_VALID = '0;
    bus.WROUTE_MST   = '0;
    for (int s = 0; s < NUM_S; s++) begin
      if (state_q[s] == BUSY) begin
        g = int'(gnt_q[s]);
        bus.AWVALID_S[s]                  = bus.AWVALID_M[g];
        bus.AWID_S[s*IW +: IW]            = {gnt_q[s], bus.AWID_M[g*ID_W +: ID_W]};
        bus.AWADDR_S[s*ADDR_W +: ADDR_W]  = bus.AWADDR_M[g*ADDR_W +: ADDR_W];
        bus.AWLEN_S[s*LEN_W +: LEN_W]     = bus.AWLEN_M[g*LEN_W +: LEN_W];
        bus.AWSIZE_S[s*SIZE_W +: SIZE_W]  = bus.AWSIZE_M[g*SIZE_W +: SIZE_W];
        bus.AWBURST_S[s*2 +: 2]           = bus.AWBURST_M[g*2 +: 2];
        if (bus.AWREADY_S[s]) bus.AWREADY_M[g] = 1'b1;
        hs[s]                             = bus.AWVALID_M[g] && bus.AWREADY_S[s];
        bus.WROUTE_VALID[s]               = hs[s];
        bus.WROUTE_MST[s*MW +: MW]        = gnt_q[s];
      end
    end
  end

  // A grant is only issued when the route FIFO can take the entry its handshake will push.
  always_comb begin
    for (int s = 0; s < NUM_S; s++) begin
      state_d[s] = state_q[s];
      gnt_d[s]   = gnt_q[s];
      ptr_d[s]   = ptr_q[s];
      case (state_q[s])
        IDLE: begin
          if (pick_vld[s] && bus.WROUTE_READY[s]) begin
            gnt_d[s]   = pick_m[s];
            state_d[s] = BUSY;
          end
        end
        BUSY: begin
          if (hs[s]) begin
            state_d[s] = IDLE;
            ptr_d[s]   = (int'(gnt_q[s]) == NUM_M-1) ? '0 : gnt_q[s] + MW'(1);
          end
        end
      endcase
    end
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      for (int s = 0; s < NUM_S; s++) begin
        state_q[s] <= IDLE;
        gnt_q[s]   <= '0;
        ptr_q[s]   <= '0;
      end
    end else begin
      for (int s = 0; s < NUM_S; s++) begin
        state_q[s] <= state_d[s];
        gnt_q[s]   <= gnt_d[s];
        ptr_q[s]   <= ptr_d[s];
      end
    end
  end
endmodule

// File: tb/tb_aw_xbar_router.sv
// Bench for aw_xbar_router: directed timing checks plus randomized rounds scored against
// a round-robin order model, with a decoupled handshake monitor popping per-slave queues.
module tb_aw_xbar_router;
  localparam int NUM_M   = 3;
  localparam int NUM_S   = 8;
  localparam int ID_W    = 4;
  localparam int ADDR_W  = 32;
  localparam int LEN_W   = 4;
  localparam int SIZE_W  = 3;
  localparam int SEL_LSB = 16;
  localparam int MW      = $clog2(NUM_M);
  localparam int SW      = $clog2(NUM_S);
  localparam int IW      = ID_W + MW;

  typedef struct {
    int                m;
    logic [ID_W-1:0]   id;
    logic [ADDR_W-1:0] addr;
    logic [LEN_W-1:0]  len;
    logic [SIZE_W-1:0] size;
    logic [1:0]        burst;
  } aw_t;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  aw_t              cur [NUM_M];
  aw_t              exp_q [NUM_S][$];
  int               mptr [NUM_S];
  logic [NUM_M-1:0] pend;
  bit               rand_bp;
  int               rec_n;
  int               rec_m [4];
  int               rec_c [4];

  aw_xbar_router_if #(
    .NUM_M(NUM_M), .NUM_S(NUM_S), .ID_W(ID_W),
    .ADDR_W(ADDR_W), .LEN_W(LEN_W), .SIZE_W(SIZE_W)
  ) bus ();

  aw_xbar_router #(
    .NUM_M(NUM_M), .NUM_S(NUM_S), .ID_W(ID_W), .ADDR_W(ADDR_W),
    .LEN_W(LEN_W), .SIZE_W(SIZE_W), .SEL_LSB(SEL_LSB)
  ) dut (
    .ACLK   (clk),
    .ARESET (rst),
    .bus    (bus.master)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout got=running expected=finished");
    $fatal(1, "simulation time limit");
  end

  function automatic int dec_slave(input logic [ADDR_W-1:0] a);
    int v;
    v = int'(a[SEL_LSB +: SW]);
    if (v >= NUM_S) v = NUM_S - 1;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=0x%0h expected=0x%0h", name, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic set_aw(input int m, input logic [ID_W-1:0] id, input logic [ADDR_W-1:0] addr,
                        input logic [LEN_W-1:0] len, input logic [SIZE_W-1:0] size,
                        input logic [1:0] burst);
    cur[m].m     = m;
    cur[m].id    = id;
    cur[m].addr  = addr;
    cur[m].len   = len;
    cur[m].size  = size;
    cur[m].burst = burst;
  endtask

  // All selected masters raise AWVALID together against idle slaves, so each slave serves
  // its requesters in rotation order starting from that slave's pointer.
  task automatic start_round(input logic [NUM_M-1:0] mask);
    int last;
    int m;
    for (int i = 0; i < NUM_M; i++) begin
      if (mask[i]) begin
        bus.AWID_M[i*ID_W +: ID_W]       = cur[i].id;
        bus.AWADDR_M[i*ADDR_W +: ADDR_W] = cur[i].addr;
        bus.AWLEN_M[i*LEN_W +: LEN_W]    = cur[i].len;
        bus.AWSIZE_M[i*SIZE_W +: SIZE_W] = cur[i].size;
        bus.AWBURST_M[i*2 +: 2]          = cur[i].burst;
        bus.AWVALID_M[i]                 = 1'b1;
        pend[i]                          = 1'b1;
      end
    end
    for (int s = 0; s < NUM_S; s++) begin
      last = -1;
      for (int k = 0; k < NUM_M; k++) begin
        m = (mptr[s] + k) % NUM_M;
        if (mask[m] && dec_slave(cur[m].addr) == s) begin
          exp_q[s].push_back(cur[m]);
          last = m;
        end
      end
      if (last >= 0) mptr[s] = (last + 1) % NUM_M;
    end
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (pend != '0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (pend != '0) begin
      bad++;
      $display("FAIL round_timeout got_pending=%b expected=%b", pend, {NUM_M{1'b0}});
      bus.AWVALID_M = '0;
      pend          = '0;
    end
  endtask

  task automatic record_hs(input int s, input int ncyc);
    rec_n = 0;
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      if (bus.AWVALID_S[s] && bus.AWREADY_S[s]) begin
        if (rec_n < 4) begin
          rec_m[rec_n] = int'(bus.AWID_S[s*IW+ID_W +: MW]);
          rec_c[rec_n] = i;
        end
        rec_n++;
      end
    end
  endtask

  // Drops AWVALID after each completed handshake; optionally randomizes backpressure.
  task automatic driver();
    logic [NUM_M-1:0] acc;
    forever begin
      @(negedge clk);
      acc = '0;
      for (int m = 0; m < NUM_M; m++) begin
        if (pend[m] && bus.AWVALID_M[m] && bus.AWREADY_M[m]) acc[m] = 1'b1;
      end
      @(posedge clk);
      #1;
      for (int m = 0; m < NUM_M; m++) begin
        if (acc[m]) begin
          bus.AWVALID_M[m] = 1'b0;
          pend[m]          = 1'b0;
        end
      end
      if (rand_bp) begin
        bus.AWREADY_S    = NUM_S'($urandom);
        bus.WROUTE_READY = NUM_S'($urandom | $urandom);
      end
    end
  endtask

  task automatic monitor();
    aw_t               e;
    int                gm;
    logic [IW-1:0]     gid;
    logic [ADDR_W-1:0] ga;
    logic [LEN_W-1:0]  gl;
    logic [SIZE_W-1:0] gs;
    logic [1:0]        gb;
    logic [MW-1:0]     rm;
    forever begin
      @(negedge clk);
      if (!rst) begin
        for (int s = 0; s < NUM_S; s++) begin
          if (bus.AWVALID_S[s] && bus.AWREADY_S[s]) begin
            gid = bus.AWID_S[s*IW +: IW];
            gm  = int'(gid[IW-1:ID_W]);
            ga  = bus.AWADDR_S[s*ADDR_W +: ADDR_W];
            gl  = bus.AWLEN_S[s*LEN_W +: LEN_W];
            gs  = bus.AWSIZE_S[s*SIZE_W +: SIZE_W];
            gb  = bus.AWBURST_S[s*2 +: 2];
            total++;
            if (exp_q[s].size() == 0) begin
              bad++;
              $display("FAIL sb_unexpected slave=%0d got_master=%0d expected=none", s, gm);
            end else begin
              e = exp_q[s].pop_front();
              if (gm != e.m || gid[ID_W-1:0] !== e.id || ga !== e.addr || gl !== e.len ||
                  gs !== e.size || gb !== e.burst) begin
                bad++;
                $display("FAIL sb_aw slave=%0d got m=%0d id=%h addr=%h len=%h size=%h burst=%h expected m=%0d id=%h addr=%h len=%h size=%h burst=%h",
                         s, gm, gid[ID_W-1:0], ga, gl, gs, gb, e.m, e.id, e.addr, e.len, e.size, e.burst);
              end
              rm = bus.WROUTE_MST[s*MW +: MW];
              total++;
              if (!bus.WROUTE_VALID[s] || int'(rm) != e.m || !bus.AWREADY_M[e.m]) begin
                bad++;
                $display("FAIL sb_route slave=%0d got wvalid=%b mst=%0d awready_m=%b expected wvalid=1 mst=%0d",
                         s, bus.WROUTE_VALID[s], rm, bus.AWREADY_M, e.m);
              end
            end
          end else begin
            total++;
            if (bus.WROUTE_VALID[s]) begin
              bad++;
              $display("FAIL sb_route_spurious slave=%0d got=1 expected=0", s);
            end
          end
        end
      end
    end
  endtask

  initial begin
    total   = 0;
    bad     = 0;
    rst     = 1'b1;
    pend    = '0;
    rand_bp = 1'b0;
    for (int s = 0; s < NUM_S; s++) mptr[s] = 0;
    bus.AWID_M       = '0;
    bus.AWADDR_M     = '0;
    bus.AWLEN_M      = '0;
    bus.AWSIZE_M     = '0;
    bus.AWBURST_M    = '0;
    bus.AWVALID_M    = '0;
    bus.AWREADY_S    = '0;
    bus.WROUTE_READY = '1;

    fork
      monitor();
      driver();
    join_none

    repeat (3) @(negedge clk);
    chk("rst_awready_m", 64'(bus.AWREADY_M), 0);
    chk("rst_awvalid_s", 64'(bus.AWVALID_S), 0);
    chk("rst_wroute_valid", 64'(bus.WROUTE_VALID), 0);
    cyc();
    rst = 1'b0;

    // Single AW: one-cycle latency, extended ID, route push.
    cyc();
    bus.AWREADY_S = NUM_S'(8'h04);
    set_aw(0, 4'h5, 32'h0002_0000, 4'h3, 3'h2, 2'b01);
    start_round(3'b001);
    @(negedge clk);
    chk("t1_lat0_awvalid_s2", 64'(bus.AWVALID_S[2]), 0);
    @(negedge clk);
    chk("t1_awvalid_s2", 64'(bus.AWVALID_S[2]), 1);
    chk("t1_awid_s2", 64'(bus.AWID_S[2*IW +: IW]), 64'h05);
    chk("t1_awready_m", 64'(bus.AWREADY_M), 64'b001);
    chk("t1_wroute_valid", 64'(bus.WROUTE_VALID), 64'h04);
    chk("t1_wroute_mst", 64'(bus.WROUTE_MST[2*MW +: MW]), 0);
    wait_done(20);

    // Three-way contention on slave 1, then a second round after the pointer wraps.
    for (int r = 0; r < 2; r++) begin
      cyc();
      bus.AWREADY_S = '1;
      set_aw(0, 4'h1, 32'h0001_0010, 4'h0, 3'h0, 2'b00);
      set_aw(1, 4'h2, 32'h0001_0020, 4'h1, 3'h1, 2'b01);
      set_aw(2, 4'h3, 32'h0001_0030, 4'h2, 3'h2, 2'b10);
      start_round(3'b111);
      record_hs(1, 10);
      chk("t2_count", 64'(rec_n), 3);
      chk("t2_first", 64'(rec_m[0]), 0);
      chk("t2_second", 64'(rec_m[1]), 1);
      chk("t2_third", 64'(rec_m[2]), 2);
      chk("t2_gap01", 64'(rec_c[1] - rec_c[0]), 2);
      chk("t2_gap12", 64'(rec_c[2] - rec_c[1]), 2);
      wait_done(5);
    end

    // Two slaves handshake in the same cycle.
    cyc();
    set_aw(0, 4'hA, 32'h0000_1000, 4'h4, 3'h3, 2'b01);
    set_aw(1, 4'hB, 32'h0005_2000, 4'h5, 3'h1, 2'b10);
    start_round(3'b011);
    @(negedge clk);
    @(negedge clk);
    chk("t3_awvalid_s", 64'(bus.AWVALID_S), 64'h21);
    chk("t3_wroute_valid", 64'(bus.WROUTE_VALID), 64'h21);
    wait_done(20);

    // Grant held under slave backpressure while another master waits.
    cyc();
    bus.AWREADY_S = NUM_S'(8'hF7);
    set_aw(0, 4'h6, 32'h0003_0100, 4'h1, 3'h2, 2'b01);
    set_aw(1, 4'h7, 32'h0003_0200, 4'h2, 3'h2, 2'b01);
    start_round(3'b011);
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t4_hold_valid", 64'(bus.AWVALID_S[3]), 1);
      chk("t4_hold_master", 64'(bus.AWID_S[3*IW+ID_W +: MW]), 0);
      chk("t4_hold_awready_m", 64'(bus.AWREADY_M), 0);
    end
    cyc();
    bus.AWREADY_S[3] = 1'b1;
    @(negedge clk);
    chk("t4_hs_awready_m", 64'(bus.AWREADY_M), 64'b001);
    @(negedge clk);
    chk("t4_gap_valid", 64'(bus.AWVALID_S[3]), 0);
    chk("t4_gap_awready_m1", 64'(bus.AWREADY_M[1]), 0);
    @(negedge clk);
    chk("t4_m1_valid", 64'(bus.AWVALID_S[3]), 1);
    chk("t4_m1_master", 64'(bus.AWID_S[3*IW+ID_W +: MW]), 1);
    wait_done(20);

    // Route FIFO full blocks the grant.
    cyc();
    bus.AWREADY_S    = '1;
    bus.WROUTE_READY = NUM_S'(8'hEF);
    set_aw(2, 4'h9, 32'h0004_0040, 4'h7, 3'h2, 2'b01);
    start_round(3'b100);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t5_blocked", 64'(bus.AWVALID_S[4]), 0);
    end
    cyc();
    bus.WROUTE_READY = '1;
    @(negedge clk);
    chk("t5_still_idle", 64'(bus.AWVALID_S[4]), 0);
    @(negedge clk);
    chk("t5_released", 64'(bus.AWVALID_S[4]), 1);
    wait_done(20);

    // Asynchronous reset mid-transfer, then a 3-way tie must go to master 0.
    cyc();
    bus.AWREADY_S = NUM_S'(8'hBF);
    set_aw(1, 4'hC, 32'h0006_0000, 4'h0, 3'h0, 2'b00);
    start_round(3'b010);
    @(negedge clk);
    @(negedge clk);
    chk("t6_busy_valid", 64'(bus.AWVALID_S[6]), 1);
    cyc();
    bus.AWREADY_S[6] = 1'b1;
    #1;
    chk("t6_pre_wroute", 64'(bus.WROUTE_VALID[6]), 1);
    rst = 1'b1;
    #1;
    chk("t6_rst_awvalid_s", 64'(bus.AWVALID_S), 0);
    chk("t6_rst_awready_m", 64'(bus.AWREADY_M), 0);
    chk("t6_rst_wroute", 64'(bus.WROUTE_VALID), 0);
    bus.AWVALID_M = '0;
    pend          = '0;
    for (int s = 0; s < NUM_S; s++) begin
      exp_q[s].delete();
      mptr[s] = 0;
    end
    repeat (2) cyc();
    rst = 1'b0;
    cyc();
    set_aw(0, 4'h1, 32'h0006_0100, 4'h1, 3'h1, 2'b01);
    set_aw(1, 4'h2, 32'h0006_0200, 4'h2, 3'h1, 2'b01);
    set_aw(2, 4'h3, 32'h0006_0300, 4'h3, 3'h1, 2'b01);
    start_round(3'b111);
    @(negedge clk);
    @(negedge clk);
    chk("t6_tie_valid", 64'(bus.AWVALID_S[6]), 1);
    chk("t6_tie_winner", 64'(bus.AWID_S[6*IW+ID_W +: MW]), 0);
    wait_done(20);

    // Randomized rounds with random slave and route-FIFO backpressure.
    rand_bp = 1'b1;
    for (int r = 0; r < 60; r++) begin
      cyc();
      for (int m = 0; m < NUM_M; m++) begin
        set_aw(m, ID_W'($urandom), ADDR_W'($urandom), LEN_W'($urandom),
               SIZE_W'($urandom), 2'($urandom));
      end
      start_round(NUM_M'($urandom_range(1, (1 << NUM_M) - 1)));
      wait_done(400);
    end
    rand_bp = 1'b0;
    cyc();
    bus.AWREADY_S    = '1;
    bus.WROUTE_READY = '1;
    repeat (4) cyc();
    for (int s = 0; s < NUM_S; s++) begin
      chk("sb_drained", 64'(exp_q[s].size()), 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
